// File: rtl/trigger_csr_ctrl_if.sv
// CSR request/response bus between the debug CSR master and trigger_csr_ctrl.
// One request may be outstanding; the response holds until rsp_valid && rsp_ready.
interface trigger_csr_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/trigger_csr_ctrl.sv
// Debug trigger CSR owner: holds tselect/tdata1/tdata2, drives the Comparator,
// and turns its Match array into one latched, prioritized hit with valid/ack.
module trigger_csr_ctrl #(
    parameter  int NUM_TRIGGERS = 4,
    parameter  int NUM_SLOTS    = 4,
    localparam int TRG_W        = $clog2(NUM_TRIGGERS),
    localparam int SLT_W        = $clog2(NUM_SLOTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    trigger_csr_ctrl_if.slave                      csr,
    output logic [NUM_SLOTS-1:0][63:0]             tdata2_o,
    output logic [3:0]                             match_mode_o,
    input  logic [NUM_TRIGGERS-1:0][NUM_SLOTS-1:0] match_i,
    output logic                                   hit_valid_o,
    output logic [TRG_W-1:0]                       hit_trigger_o,
    output logic [SLT_W-1:0]                       hit_slot_o,
    input  logic                                   hit_ack_i
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e                    state_q, state_d;
    logic [63:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [SLT_W-1:0]          tsel_q, tsel_d;
    logic [3:0]                mode_q, mode_d;
    logic                      en_q, en_d;
    logic [NUM_SLOTS-1:0][63:0] tdata2_q, tdata2_d;
    logic                      stale_q, stale_d;
    logic                      hit_valid_q, hit_valid_d;
    logic [TRG_W-1:0]          hit_trg_q, hit_trg_d;
    logic [SLT_W-1:0]          hit_slt_q, hit_slt_d;

    logic                      accept;
    logic                      cfg_wr;
    logic                      found;
    logic [TRG_W-1:0]          found_trg;
    logic [SLT_W-1:0]          found_slt;

    function automatic logic mode_legal(input logic [3:0] m);
        case (m)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign accept = csr.req_valid && (state_q == ST_IDLE);

    // Lowest trigger index wins; within a trigger, lowest slot wins.
    always_comb begin
        found     = 1'b0;
        found_trg = '0;
        found_slt = '0;
        for (int i = 0; i < NUM_TRIGGERS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (!found && match_i[i][j]) begin
                    found     = 1'b1;
                    found_trg = TRG_W'(i);
                    found_slt = SLT_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tsel_d      = tsel_q;
        mode_d      = mode_q;
        en_d        = en_q;
        tdata2_d    = tdata2_q;
        hit_valid_d = hit_valid_q;
        hit_trg_d   = hit_trg_q;
        hit_slt_d   = hit_slt_q;
        cfg_wr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    case (csr.req_addr)
                        ADDR_TSELECT: begin
                            if (csr.req_we) begin
                                if (csr.req_wdata >= 64'(NUM_SLOTS)) rsp_err_d = 1'b1;
                                else tsel_d = csr.req_wdata[SLT_W-1:0];
                            end else begin
                                rsp_rdata_d = 64'(tsel_q);
                            end
                        end
                        ADDR_TDATA1: begin
                            if (csr.req_we) begin
                                cfg_wr = 1'b1;
                                if (mode_legal(csr.req_wdata[3:0])) begin
                                    mode_d = csr.req_wdata[3:0];
                                    en_d   = csr.req_wdata[4];
                                end else begin
                                    rsp_err_d = 1'b1;
                                end
                            end else begin
                                rsp_rdata_d = {59'd0, en_q, mode_q};
                            end
                        end
                        ADDR_TDATA2: begin
                            if (csr.req_we) begin
                                cfg_wr           = 1'b1;
                                tdata2_d[tsel_q] = csr.req_wdata;
                            end else begin
                                rsp_rdata_d = tdata2_q[tsel_q];
                            end
                        end
                        default: rsp_err_d = 1'b1;
                    endcase
                end
            end
            ST_RESP: begin
                if (csr.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The Comparator needs a cycle after a config write before its Match is trustworthy.
        if (hit_valid_q) begin
            if (hit_ack_i) hit_valid_d = 1'b0;
        end else if (en_q && !cfg_wr && !stale_q && found) begin
            hit_valid_d = 1'b1;
            hit_trg_d   = found_trg;
            hit_slt_d   = found_slt;
        end
    end

    assign stale_d = cfg_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tsel_q      <= '0;
            mode_q      <= '0;
            en_q        <= 1'b0;
            tdata2_q    <= '0;
            stale_q     <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_trg_q   <= '0;
            hit_slt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tsel_q      <= tsel_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            tdata2_q    <= tdata2_d;
            stale_q     <= stale_d;
            hit_valid_q <= hit_valid_d;
            hit_trg_q   <= hit_trg_d;
            hit_slt_q   <= hit_slt_d;
        end
    end

    assign csr.req_ready = (state_q == ST_IDLE);
    assign csr.rsp_valid = (state_q == ST_RESP);
    assign csr.rsp_rdata = rsp_rdata_q;
    assign csr.rsp_err   = rsp_err_q;
    assign tdata2_o      = tdata2_q;
    assign match_mode_o  = mode_q;
    assign hit_valid_o   = hit_valid_q;
    assign hit_trigger_o = hit_trg_q;
    assign hit_slot_o    = hit_slt_q;

endmodule

// File: tb/tb_trigger_csr_ctrl.sv
// Bench for trigger_csr_ctrl: CSR responses go through an expected-value queue,
// hit capture behaviour is checked inline per scenario.
module tb_trigger_csr_ctrl;

    logic            clk;
    logic            rst;
    logic [3:0][3:0] match;
    logic            hit_ack;
    logic [3:0][63:0] tdata2;
    logic [3:0]      match_mode;
    logic            hit_valid;
    logic [1:0]      hit_trigger;
    logic [1:0]      hit_slot;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    trigger_csr_ctrl_if bus();

    trigger_csr_ctrl #(.NUM_TRIGGERS(4), .NUM_SLOTS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr          (bus),
        .tdata2_o     (tdata2),
        .match_mode_o (match_mode),
        .match_i      (match),
        .hit_valid_o  (hit_valid),
        .hit_trigger_o(hit_trigger),
        .hit_slot_o   (hit_slot),
        .hit_ack_i    (hit_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Pop the oldest expectation and compare it against the response on the bus.
    task automatic sb_check(input string name);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got rsp rdata=%h", name, bus.rsp_rdata);
        end else begin
            e = sb_q.pop_front();
            if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                tests_failed++;
                $display("FAIL %s: got rdata=%h err=%b want rdata=%h err=%b",
                         name, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
        end
    endtask

    task automatic csr_xfer(input logic we, input logic [11:0] addr, input logic [63:0] wdata,
                            input logic [63:0] exp_rdata, input logic exp_err, input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (bus.rsp_valid !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_rsp_timeout: got rsp_valid=%b want 1", name, bus.rsp_valid);
            void'(sb_q.pop_front());
        end else begin
            sb_check(name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 64'd0 ||
            bus.rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_bus: got rsp_valid=%b req_ready=%b rdata=%h err=%b want 0 1 0 0",
                     bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
        end
        tests_run++;
        if (hit_valid !== 1'b0 || hit_trigger !== 2'd0 || hit_slot !== 2'd0 ||
            match_mode !== 4'd0 || tdata2 !== '0) begin
            tests_failed++;
            $display("FAIL reset_cfg: got hit=%b trg=%0d slot=%0d mode=%0d tdata2=%h want all 0",
                     hit_valid, hit_trigger, hit_slot, match_mode, tdata2);
        end
        rst = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 12'h7A1;
        bus.req_wdata = '0;
        sb_q.push_back('{rdata: 64'd0, err: 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_rdata !== 64'd0 ||
                bus.rsp_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL rsp_hold_%0d: got rsp_valid=%b req_ready=%b rdata=%h err=%b want 1 0 0 0",
                         k, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err);
            end
            if (k < 2) @(negedge clk);
        end
        sb_check("read_tdata1_reset");
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rsp_release: got rsp_valid=%b req_ready=%b want 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_tdata2();
        csr_xfer(1'b1, 12'h7A0, 64'd2, 64'd0, 1'b0, "wr_tselect_2");
        tests_run++;
        if (tdata2[2] !== 64'd0) begin
            tests_failed++;
            $display("FAIL tdata2_pre: got %h want 0", tdata2[2]);
        end
        csr_xfer(1'b1, 12'h7A2, 64'h0000_0000_DEAD_BEEF, 64'd0, 1'b0, "wr_tdata2");
        tests_run++;
        if (tdata2[2] !== 64'h0000_0000_DEAD_BEEF || tdata2[0] !== 64'd0 ||
            tdata2[1] !== 64'd0 || tdata2[3] !== 64'd0) begin
            tests_failed++;
            $display("FAIL tdata2_out: got %h want slot2=deadbeef others 0", tdata2);
        end
        csr_xfer(1'b0, 12'h7A2, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0, "rd_tdata2");
    endtask

    task automatic test_tdata1();
        csr_xfer(1'b1, 12'h7A1, 64'h1A, 64'd0, 1'b1, "wr_tdata1_illegal");
        tests_run++;
        if (match_mode !== 4'd0) begin
            tests_failed++;
            $display("FAIL mode_after_illegal: got %0d want 0", match_mode);
        end
        csr_xfer(1'b1, 12'h7A1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0, "wr_tdata1_legal");
        tests_run++;
        if (match_mode !== 4'd9) begin
            tests_failed++;
            $display("FAIL mode_after_legal: got %0d want 9", match_mode);
        end
        csr_xfer(1'b0, 12'h7A1, 64'd0, 64'h19, 1'b0, "rd_tdata1");
    endtask

    task automatic test_errors();
        csr_xfer(1'b1, 12'h7A0, 64'd7, 64'd0, 1'b1, "wr_tselect_7");
        csr_xfer(1'b0, 12'h7A0, 64'd0, 64'd2, 1'b0, "rd_tselect");
        csr_xfer(1'b0, 12'h7A5, 64'd0, 64'd0, 1'b1, "rd_unknown");
        csr_xfer(1'b1, 12'h7A5, 64'h55, 64'd0, 1'b1, "wr_unknown");
        csr_xfer(1'b0, 12'h7A2, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0, "rd_tdata2_again");
    endtask

    task automatic test_hit_priority();
        @(negedge clk);
        match = '0;
        match[1][3] = 1'b1;
        match[2][0] = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd1 || hit_slot !== 2'd3) begin
            tests_failed++;
            $display("FAIL hit_first: got v=%b t=%0d s=%0d want 1 1 3", hit_valid, hit_trigger, hit_slot);
        end
        match[1][3] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd1 || hit_slot !== 2'd3) begin
            tests_failed++;
            $display("FAIL hit_hold: got v=%b t=%0d s=%0d want 1 1 3", hit_valid, hit_trigger, hit_slot);
        end
        match[1][3] = 1'b1;
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
        tests_run++;
        if (hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_clear: got v=%b want 0", hit_valid);
        end
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd1 || hit_slot !== 2'd3) begin
            tests_failed++;
            $display("FAIL recapture: got v=%b t=%0d s=%0d want 1 1 3", hit_valid, hit_trigger, hit_slot);
        end
        match = '0;
        match[3][0] = 1'b1;
        match[2][1] = 1'b1;
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd2 || hit_slot !== 2'd1) begin
            tests_failed++;
            $display("FAIL hit_prio2: got v=%b t=%0d s=%0d want 1 2 1", hit_valid, hit_trigger, hit_slot);
        end
    endtask

    task automatic test_enable_clear();
        csr_xfer(1'b1, 12'h7A1, 64'h09, 64'd0, 1'b0, "wr_tdata1_disable");
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd2 || hit_slot !== 2'd1 || match_mode !== 4'd9) begin
            tests_failed++;
            $display("FAIL disable_keeps_hit: got v=%b t=%0d s=%0d mode=%0d want 1 2 1 9",
                     hit_valid, hit_trigger, hit_slot, match_mode);
        end
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL disabled_no_capture: got v=%b want 0", hit_valid);
        end
        match = '0;
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
        tests_run++;
        if (hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ack: got v=%b want 0", hit_valid);
        end
    endtask

    task automatic test_stale_window();
        csr_xfer(1'b1, 12'h7A1, 64'h19, 64'd0, 1'b0, "wr_tdata1_enable");
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 12'h7A2;
        bus.req_wdata = 64'h1234_5678_9ABC_DEF0;
        sb_q.push_back('{rdata: 64'd0, err: 1'b0});
        match = '1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests_run++;
        if (hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_edge1: got v=%b want 0", hit_valid);
        end
        sb_check("wr_tdata2_stale");
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_edge2: got v=%b want 0", hit_valid);
        end
        @(negedge clk);
        tests_run++;
        if (hit_valid !== 1'b1 || hit_trigger !== 2'd0 || hit_slot !== 2'd0) begin
            tests_failed++;
            $display("FAIL stale_edge3: got v=%b t=%0d s=%0d want 1 0 0", hit_valid, hit_trigger, hit_slot);
        end
        match = '0;
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 12'h7A0;
        sb_q.push_back('{rdata: 64'd2, err: 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b0;
        sb_check("rd_tselect_pending");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || hit_valid !== 1'b0 ||
            match_mode !== 4'd0 || tdata2 !== '0) begin
            tests_failed++;
            $display("FAIL midflight_reset: got rsp_valid=%b ready=%b hit=%b mode=%0d tdata2=%h want 0 1 0 0 0",
                     bus.rsp_valid, bus.req_ready, hit_valid, match_mode, tdata2);
        end
        csr_xfer(1'b0, 12'h7A0, 64'd0, 64'd0, 1'b0, "rd_tselect_after_reset");
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        match         = '0;
        hit_ack       = 1'b0;

        test_reset();
        test_tdata2();
        test_tdata1();
        test_errors();
        test_hit_priority();
        test_enable_clear();
        test_stale_window();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trigger_csr_ctrl.md
Name: trigger_csr_ctrl

Overview:
- CSR-side owner of the debug trigger match path. It holds the trigger configuration (a global tdata1 and one tdata2 per slot) and drives the tdata2/match_mode inputs of the Comparator.
- It consumes the Comparator's Match array and converts it into a single latched, prioritized hit event with a valid/ack handshake toward the debug/exception logic.
- It sits between the CSR request bus and the Comparator.

Parameters:
- num_triggers, 4, trigger rows in the Match array.
- num_slots, 4, slots (tdata2 registers); tselect legal range 0..num_slots-1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets).
- req_valid  input  1  CSR request valid.
- req_ready  output  1  CSR request ready.
- req_we  input  1  1=write, 0=read.
- req_addr  input  12  CSR address: 0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2.
- req_wdata  input  64  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_rdata  output  64  read data (0 for writes and errors).
- rsp_err  output  1  access error.
- tdata2  output  64 x [num_slots]  to Comparator tdata2.
- match_mode  output  4  to Comparator match_mode.
- match  input  1 x [num_triggers][num_slots]  from Comparator Match.
- hit_valid  output  1  latched hit pending.
- hit_trigger  output  $clog2(num_triggers)  trigger index of the hit.
- hit_slot  output  $clog2(num_slots)  slot index of the hit.
- hit_ack  input  1  clears hit_valid.

Behaviour:
- Reset values:
  - tselect=0; tdata1=0 (so match_mode=0, enable=0); all tdata2=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; hit_valid=0, hit_trigger=0, hit_slot=0; req_ready=1.
  - Reset mid-transaction drops any pending response and any pending hit.
- Handshake:
  - req_ready = !rsp_valid (one outstanding request).
  - A request is accepted on an edge with req_valid&&req_ready.
  - rsp_valid rises the next cycle and holds, with rdata/err stable, until rsp_valid&&rsp_ready.
  - Throughput is one request per 2 cycles when rsp_ready is tied 1.
- tdata1 layout:
  - [3:0] match mode, [4] enable; all other bits read 0 and ignore writes.
  - Legal modes: 0,1,2,3,4,5,8,9,12,13.
  - A write with an illegal mode leaves the whole of tdata1 unchanged and sets rsp_err=1.
  - match_mode = tdata1[3:0] combinationally from the register.
- tselect:
  - A write of a value >= num_slots is ignored, with rsp_err=1.
  - Reads return the zero-extended value.
- tdata2: reads and writes target tdata2[tselect], full 64 bits.
- Unknown address: no state change, rsp_err=1, rsp_rdata=0.
- Write timing: a write updates its register on the accept edge, so outputs change in the cycle after acceptance. Reads return the value as of the accept edge.
- Hit capture:
  - On each edge where rst=1, enable=1, hit_valid=0, and no stale window is active, capture the lowest (i, j) with match[i][j]=1. Scan i ascending first, then j ascending.
  - On capture: hit_valid=1, hit_trigger=i, hit_slot=j.
  - If no bit is set, nothing changes.
- Stale window: capture is suppressed on the accept edge of any tdata1/tdata2 write and on the following edge, so the Comparator output reflects the new configuration before it is sampled.
- While hit_valid=1, hit_trigger/hit_slot hold regardless of match.
- hit_ack:
  - hit_ack with hit_valid=1 clears hit_valid on that edge; no new capture occurs on the same edge, and capture resumes on the next edge.
  - hit_ack with hit_valid=0 is ignored.
- Clearing enable (a write of tdata1 with [4]=0) does not clear a pending hit.

Test Plan:
- Reset, then read 0x7A1 -> rsp next cycle, rdata=0, err=0; req_ready low while rsp_valid is held with rsp_ready=0 for 3 cycles.
- Write tselect=2, write tdata2=0x0000_0000_DEAD_BEEF, read 0x7A2 -> rdata 0xDEADBEEF; tdata2[2] updates one cycle after accept; tdata2[0,1,3] stay 0.
- Write tdata1=0x1A (mode 10, illegal) -> err=1, match_mode stays 0. Write 0x19 -> err=0, match_mode=9, enable=1.
- Write tselect=7 with num_slots=4 -> err=1, reading tselect returns the prior value. Read of address 0x7A5 -> err=1, rdata=0.
- enable=1 and match[1][3], match[2][0] set together -> hit_valid=1, hit_trigger=1, hit_slot=3. Holding hit_ack=1 for one cycle clears it with no same-edge recapture; the next edge recaptures (1,3) if it is still set.
- Write tdata2 then drive match=all-ones on the accept edge and the following edge -> no capture; capture occurs on the 3rd edge.
